// File: rtl/rocc_cmd_arbiter.sv
// Arbitrates several core-side RoCC command ports onto one accelerator port and
// routes responses back to the issuing port through an in-order tag FIFO.
module rocc_cmd_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int XLEN      = 64,
  parameter int TAG_DEPTH = 4,
  localparam int CMD_W    = 32 + 2 * XLEN,
  localparam int RESP_W   = 5 + XLEN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PORTS-1:0]       in_cmd_valid,
  output logic [NUM_PORTS-1:0]       in_cmd_ready,
  input  logic [NUM_PORTS*CMD_W-1:0] in_cmd_bits,
  input  logic [NUM_PORTS-1:0]       in_s,
  output logic [NUM_PORTS-1:0]       in_resp_valid,
  input  logic [NUM_PORTS-1:0]       in_resp_ready,
  output logic [RESP_W-1:0]          in_resp_bits,
  output logic [NUM_PORTS-1:0]       in_busy,
  output logic [NUM_PORTS-1:0]       in_interrupt,
  output logic                       out_cmd_valid,
  input  logic                       out_cmd_ready,
  output logic [CMD_W-1:0]           out_cmd_bits,
  output logic                       out_s,
  input  logic                       out_resp_valid,
  output logic                       out_resp_ready,
  input  logic [RESP_W-1:0]          out_resp_bits,
  input  logic                       out_busy,
  input  logic                       out_interrupt,
  output logic                       err_orphan_resp
);

  localparam int PTR_W   = $clog2(NUM_PORTS);
  localparam int CNT_W   = $clog2(TAG_DEPTH + 1);
  localparam int FIFO_AW = $clog2(TAG_DEPTH);
  localparam int XD_BIT  = 2 * XLEN + 14;

  logic [PTR_W-1:0]   rr_ptr;
  logic               lock;
  logic [PTR_W-1:0]   grant_q;
  logic [PTR_W-1:0]   rr_grant;
  logic [PTR_W-1:0]   grant;
  logic [PTR_W-1:0]   grant_next;
  logic [NUM_PORTS-1:0] cmd_xd;
  logic [NUM_PORTS-1:0] eligible;

  logic [PTR_W-1:0]   fifo_mem [TAG_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [PTR_W-1:0]   head;

  logic [CNT_W-1:0]   outstanding [NUM_PORTS];
  logic [NUM_PORTS-1:0] cnt_inc;
  logic [NUM_PORTS-1:0] cnt_dec;

  logic cmd_fire;
  logic resp_fire;
  logic push;
  logic pop;

  assign fifo_full  = (fifo_count == CNT_W'(TAG_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign head       = fifo_mem[rd_ptr];

  // A port needing a response tag may only compete while a tag slot is free.
  always_comb begin
    cmd_xd   = '0;
    eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cmd_xd[i]   = in_cmd_bits[i*CMD_W + XD_BIT];
      eligible[i] = in_cmd_valid[i] && (!cmd_xd[i] || !fifo_full);
    end
  end

  always_comb begin
    rr_grant = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (eligible[idx]) rr_grant = PTR_W'(idx);
    end
  end

  assign grant         = (lock && eligible[grant_q]) ? grant_q : rr_grant;
  assign grant_next    = (grant == PTR_W'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
  assign out_cmd_valid = |eligible;
  assign out_cmd_bits  = in_cmd_bits[int'(grant)*CMD_W +: CMD_W];
  assign out_s         = in_s[grant];
  assign cmd_fire      = out_cmd_valid && out_cmd_ready;
  assign push          = cmd_fire && cmd_xd[grant] && !fifo_full;

  always_comb begin
    in_cmd_ready = '0;
    if (cmd_fire) in_cmd_ready[grant] = 1'b1;
  end

  // A stalled offer stays with the same port so its bits never change under the accelerator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr  <= '0;
      lock    <= 1'b0;
      grant_q <= '0;
    end else if (cmd_fire) begin
      rr_ptr <= grant_next;
      lock   <= 1'b0;
    end else if (out_cmd_valid) begin
      lock    <= 1'b1;
      grant_q <= grant;
    end
  end

  // With no tag outstanding, a response is swallowed so the accelerator cannot hang.
  always_comb begin
    in_resp_valid  = '0;
    out_resp_ready = 1'b1;
    if (!fifo_empty) begin
      in_resp_valid[head] = out_resp_valid;
      out_resp_ready      = in_resp_ready[head];
    end
  end

  assign in_resp_bits = out_resp_bits;
  assign resp_fire    = out_resp_valid && out_resp_ready;
  assign pop          = resp_fire && !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= grant;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cnt_inc[i] = push && (grant == PTR_W'(i));
      cnt_dec[i] = pop && (head == PTR_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PORTS; i++) outstanding[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (cnt_inc[i] && !cnt_dec[i])
          outstanding[i] <= outstanding[i] + 1'b1;
        else if (cnt_dec[i] && !cnt_inc[i] && outstanding[i] != '0)
          outstanding[i] <= outstanding[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err_orphan_resp <= 1'b0;
    else if (out_resp_valid && fifo_empty)
      err_orphan_resp <= 1'b1;
  end

  always_comb begin
    in_busy      = '0;
    in_interrupt = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      in_busy[i]      = out_busy || (outstanding[i] != '0);
      in_interrupt[i] = out_interrupt;
    end
  end

endmodule

// File: tb/tb_rocc_cmd_arbiter.sv
// Scoreboard bench for rocc_cmd_arbiter: expected grants and response routes are
// queued as stimulus is driven and compared whenever a handshake is observed.
module tb_rocc_cmd_arbiter;

  localparam int NP     = 2;
  localparam int XL     = 64;
  localparam int CMD_W  = 32 + 2 * XL;
  localparam int RESP_W = 5 + XL;

  logic                clk = 1'b0;
  logic                reset;
  logic [NP-1:0]       in_cmd_valid;
  logic [NP-1:0]       in_cmd_ready;
  logic [NP*CMD_W-1:0] in_cmd_bits;
  logic [NP-1:0]       in_s;
  logic [NP-1:0]       in_resp_valid;
  logic [NP-1:0]       in_resp_ready;
  logic [RESP_W-1:0]   in_resp_bits;
  logic [NP-1:0]       in_busy;
  logic [NP-1:0]       in_interrupt;
  logic                out_cmd_valid;
  logic                out_cmd_ready;
  logic [CMD_W-1:0]    out_cmd_bits;
  logic                out_s;
  logic                out_resp_valid;
  logic                out_resp_ready;
  logic [RESP_W-1:0]   out_resp_bits;
  logic                out_busy;
  logic                out_interrupt;
  logic                err_orphan_resp;

  int checks = 0;
  int errors = 0;
  int cmd_seen = 0;
  int resp_seen = 0;
  int orphan_seen = 0;

  int               exp_cmd_port_q[$];
  logic [CMD_W-1:0] exp_cmd_bits_q[$];
  logic             exp_cmd_s_q[$];
  int               exp_resp_port_q[$];
  logic [RESP_W-1:0] exp_resp_bits_q[$];

  always #5 clk = ~clk;

  rocc_cmd_arbiter #(.NUM_PORTS(NP), .XLEN(XL), .TAG_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_cmd_valid(in_cmd_valid), .in_cmd_ready(in_cmd_ready), .in_cmd_bits(in_cmd_bits),
    .in_s(in_s), .in_resp_valid(in_resp_valid), .in_resp_ready(in_resp_ready),
    .in_resp_bits(in_resp_bits), .in_busy(in_busy), .in_interrupt(in_interrupt),
    .out_cmd_valid(out_cmd_valid), .out_cmd_ready(out_cmd_ready), .out_cmd_bits(out_cmd_bits),
    .out_s(out_s), .out_resp_valid(out_resp_valid), .out_resp_ready(out_resp_ready),
    .out_resp_bits(out_resp_bits), .out_busy(out_busy), .out_interrupt(out_interrupt),
    .err_orphan_resp(err_orphan_resp)
  );

  task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [CMD_W-1:0] makeCmd(input logic xd, input logic [4:0] rd, input logic [63:0] data);
    return {7'h2a, 5'd3, 5'd4, xd, 1'b1, 1'b0, rd, 7'h0b, data, ~data};
  endfunction

  task automatic expectCmd(input int port, input logic [CMD_W-1:0] bits);
    exp_cmd_port_q.push_back(port);
    exp_cmd_bits_q.push_back(bits);
    exp_cmd_s_q.push_back(port == 1);
  endtask

  task automatic expectResp(input int port, input logic [RESP_W-1:0] bits);
    exp_resp_port_q.push_back(port);
    exp_resp_bits_q.push_back(bits);
  endtask

  task automatic waitCmds(input int target);
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (cmd_seen >= target) return;
    end
    checkOutput("cmd_timeout", 256'(cmd_seen), 256'(target));
  endtask

  task automatic waitResps(input int target);
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (resp_seen >= target) return;
    end
    checkOutput("resp_timeout", 256'(resp_seen), 256'(target));
  endtask

  // Issue one command from a single port and wait for its handshake.
  task automatic applyStimulus(input int port, input logic xd, input logic [4:0] rd, input logic [63:0] data);
    logic [CMD_W-1:0] c;
    c = makeCmd(xd, rd, data);
    in_cmd_bits[port*CMD_W +: CMD_W] = c;
    expectCmd(port, c);
    out_cmd_ready = 1'b1;
    in_cmd_valid[port] = 1'b1;
    waitCmds(cmd_seen + 1);
    in_cmd_valid[port] = 1'b0;
  endtask

  // Handshakes are judged at the falling edge; they complete on the next rising edge.
  always @(negedge clk) begin
    if (reset && out_cmd_valid && out_cmd_ready) begin
      if (exp_cmd_port_q.size() == 0) begin
        checkOutput("cmd_unexpected", 256'(in_cmd_ready), 256'(0));
      end else begin
        int p;
        p = exp_cmd_port_q.pop_front();
        checkOutput("cmd_grant", 256'(in_cmd_ready), 256'(1) << p);
        checkOutput("cmd_bits", 256'(out_cmd_bits), 256'(exp_cmd_bits_q.pop_front()));
        checkOutput("cmd_s", 256'(out_s), 256'(exp_cmd_s_q.pop_front()));
      end
      cmd_seen++;
    end
    if (reset && out_resp_valid && out_resp_ready) begin
      if (in_resp_valid == '0) begin
        orphan_seen++;
      end else if (exp_resp_port_q.size() == 0) begin
        checkOutput("resp_unexpected", 256'(in_resp_valid), 256'(0));
        resp_seen++;
      end else begin
        int p;
        p = exp_resp_port_q.pop_front();
        checkOutput("resp_route", 256'(in_resp_valid), 256'(1) << p);
        checkOutput("resp_bits", 256'(in_resp_bits), 256'(exp_resp_bits_q.pop_front()));
        resp_seen++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [CMD_W-1:0]  c0, c1, c3, c4;
    logic [RESP_W-1:0] r;
    reset = 1'b0;
    in_cmd_valid = '0;
    in_cmd_bits = '0;
    in_s = 2'b10;
    in_resp_ready = '0;
    out_cmd_ready = 1'b0;
    out_resp_valid = 1'b0;
    out_resp_bits = '0;
    out_busy = 1'b0;
    out_interrupt = 1'b0;

    // Reset state and purely combinational paths while reset is held.
    @(negedge clk);
    checkOutput("rst_cmd_valid", 256'(out_cmd_valid), 256'(0));
    checkOutput("rst_err", 256'(err_orphan_resp), 256'(0));
    checkOutput("rst_busy", 256'(in_busy), 256'(0));
    checkOutput("rst_resp_valid", 256'(in_resp_valid), 256'(0));
    in_cmd_bits[0 +: CMD_W] = makeCmd(1'b0, 5'd1, 64'h0123);
    in_cmd_valid = 2'b01;
    out_cmd_ready = 1'b1;
    #1 checkOutput("rst_cmd_ready", 256'(in_cmd_ready), 256'(2'b01));
    in_cmd_valid = '0;
    out_cmd_ready = 1'b0;
    out_interrupt = 1'b1;
    #1 checkOutput("rst_cmd_ready_idle", 256'(in_cmd_ready), 256'(0));
    checkOutput("interrupt_fanout", 256'(in_interrupt), 256'(2'b11));
    out_interrupt = 1'b0;
    @(posedge clk); #1 reset = 1'b1;

    // Both ports streaming xd=0 commands alternate 0,1,0,1,...
    c0 = makeCmd(1'b0, 5'd10, 64'hAAAA);
    c1 = makeCmd(1'b0, 5'd11, 64'hBBBB);
    in_cmd_bits[0 +: CMD_W] = c0;
    in_cmd_bits[CMD_W +: CMD_W] = c1;
    for (int k = 0; k < 6; k++) expectCmd(k % 2, (k % 2 == 1) ? c1 : c0);
    out_cmd_ready = 1'b1;
    in_cmd_valid = 2'b11;
    waitCmds(cmd_seen + 6);
    in_cmd_valid = '0;

    // Stalled offer from port 1 is locked against a later port-0 arrival.
    out_cmd_ready = 1'b0;
    c1 = makeCmd(1'b0, 5'd9, 64'h1111);
    in_cmd_bits[CMD_W +: CMD_W] = c1;
    in_cmd_valid = 2'b10;
    @(negedge clk);
    checkOutput("lock_offer_valid", 256'(out_cmd_valid), 256'(1));
    checkOutput("lock_offer_bits", 256'(out_cmd_bits), 256'(c1));
    @(posedge clk); #1 in_cmd_valid = 2'b11;
    @(negedge clk);
    checkOutput("lock_hold1_bits", 256'(out_cmd_bits), 256'(c1));
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("lock_hold2_bits", 256'(out_cmd_bits), 256'(c1));
    checkOutput("lock_hold2_ready", 256'(in_cmd_ready), 256'(0));
    @(posedge clk); #1;
    expectCmd(1, c1);
    expectCmd(0, c0);
    out_cmd_ready = 1'b1;
    waitCmds(cmd_seen + 1);
    in_cmd_valid[1] = 1'b0;
    waitCmds(cmd_seen + 1);
    in_cmd_valid = '0;

    // Fill the tag FIFO from port 0; a fifth xd=1 stalls while an xd=0 passes.
    c3 = makeCmd(1'b1, 5'd1, 64'hA0);
    in_cmd_bits[0 +: CMD_W] = c3;
    for (int k = 0; k < 4; k++) expectCmd(0, c3);
    in_cmd_valid = 2'b01;
    waitCmds(cmd_seen + 4);
    @(negedge clk);
    checkOutput("full_stall_valid", 256'(out_cmd_valid), 256'(0));
    checkOutput("full_stall_ready", 256'(in_cmd_ready), 256'(0));
    checkOutput("full_busy", 256'(in_busy), 256'(2'b01));
    @(posedge clk); #1;
    c4 = makeCmd(1'b0, 5'd2, 64'hB0);
    in_cmd_bits[CMD_W +: CMD_W] = c4;
    expectCmd(1, c4);
    in_cmd_valid = 2'b11;
    waitCmds(cmd_seen + 1);
    in_cmd_valid = '0;
    r = {5'd1, 64'hD0};
    out_resp_bits = r;
    for (int k = 0; k < 4; k++) expectResp(0, r);
    in_resp_ready = 2'b11;
    out_resp_valid = 1'b1;
    waitResps(resp_seen + 4);
    out_resp_valid = 1'b0;
    @(negedge clk);
    checkOutput("drained_busy", 256'(in_busy), 256'(0));

    // In-order routing of responses to ports 0,1,0 with port-1 backpressure.
    @(posedge clk); #1;
    in_resp_ready = '0;
    applyStimulus(0, 1'b1, 5'd5, 64'h50);
    applyStimulus(1, 1'b1, 5'd6, 64'h60);
    applyStimulus(0, 1'b1, 5'd7, 64'h70);
    r = {5'd5, 64'h5005};
    out_resp_bits = r;
    expectResp(0, r);
    in_resp_ready = 2'b01;
    out_resp_valid = 1'b1;
    waitResps(resp_seen + 1);
    r = {5'd6, 64'h6006};
    out_resp_bits = r;
    expectResp(1, r);
    @(negedge clk);
    checkOutput("bp_out_ready", 256'(out_resp_ready), 256'(0));
    checkOutput("bp_route", 256'(in_resp_valid), 256'(2'b10));
    checkOutput("bp_busy", 256'(in_busy), 256'(2'b11));
    @(posedge clk); #1 in_resp_ready = 2'b11;
    waitResps(resp_seen + 1);
    r = {5'd7, 64'h7007};
    out_resp_bits = r;
    expectResp(0, r);
    waitResps(resp_seen + 1);
    out_resp_valid = 1'b0;
    in_resp_ready = '0;

    // Orphan response: swallowed, flagged, sticky until reset.
    out_resp_bits = {5'd9, 64'h9009};
    out_resp_valid = 1'b1;
    @(negedge clk);
    checkOutput("orphan_out_ready", 256'(out_resp_ready), 256'(1));
    checkOutput("orphan_route", 256'(in_resp_valid), 256'(0));
    checkOutput("orphan_err_pre", 256'(err_orphan_resp), 256'(0));
    @(posedge clk); #1 out_resp_valid = 1'b0;
    checkOutput("orphan_err_set", 256'(err_orphan_resp), 256'(1));
    repeat (3) @(posedge clk);
    #1 checkOutput("orphan_err_sticky", 256'(err_orphan_resp), 256'(1));
    reset = 1'b0;
    #1 checkOutput("orphan_err_clear", 256'(err_orphan_resp), 256'(0));
    @(posedge clk); #1 reset = 1'b1;

    // Reset with two tags outstanding discards them.
    applyStimulus(0, 1'b1, 5'd3, 64'h33);
    applyStimulus(1, 1'b1, 5'd4, 64'h44);
    @(negedge clk);
    checkOutput("tags_busy", 256'(in_busy), 256'(2'b11));
    #2 reset = 1'b0;
    #1 checkOutput("rst_busy_clear", 256'(in_busy), 256'(0));
    out_busy = 1'b1;
    #1 checkOutput("ext_busy", 256'(in_busy), 256'(2'b11));
    out_busy = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    out_resp_bits = {5'd3, 64'h3003};
    out_resp_valid = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_out_ready", 256'(out_resp_ready), 256'(1));
    checkOutput("post_rst_route", 256'(in_resp_valid), 256'(0));
    @(posedge clk); #1 out_resp_valid = 1'b0;
    checkOutput("post_rst_err", 256'(err_orphan_resp), 256'(1));

    checkOutput("orphan_count", 256'(orphan_seen), 256'(2));
    checkOutput("cmd_queue_left", 256'(exp_cmd_port_q.size()), 256'(0));
    checkOutput("resp_queue_left", 256'(exp_resp_port_q.size()), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
